// File: rtl/adder_tree_arbiter.sv
// Two-requester arbiter feeding one shared 8-input adder tree, with a LATENCY-stage response pipeline.
// Latency: an accept at edge T shows rsp_valid after edge T+LATENCY-1; one transaction per cycle when not stalled.
// Backpressure: rsp_valid && !rsp_ready freezes every stage and forces gnt to 0. Define ADDER_ARB_FIXED_PRIO_EN for fixed priority.
module adder_tree_arbiter #(
  parameter int WIDTH   = 24,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [8*WIDTH-1:0] ops0,
  input  logic [8*WIDTH-1:0] ops1,
  output logic [1:0]         gnt,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH+2:0]   rsp_sum
);

  logic [LATENCY-1:0] vld_q, vld_d;
  logic               id_q  [LATENCY];
  logic               id_d  [LATENCY];
  logic [WIDTH+2:0]   sum_q [LATENCY];
  logic [WIDTH+2:0]   sum_d [LATENCY];

  logic               stall;
  logic [8*WIDTH-1:0] ops_sel;
  logic [WIDTH:0]     lvl1 [4];
  logic [WIDTH+1:0]   lvl2 [2];
  logic [WIDTH+2:0]   lvl3;

  // Outputs are gated with rst so a reset cycle never exposes a stale response.
  assign rsp_valid = vld_q[LATENCY-1] & ~rst;
  assign rsp_id    = rsp_valid & id_q[LATENCY-1];
  assign rsp_sum   = rsp_valid ? sum_q[LATENCY-1] : '0;
  assign stall     = rsp_valid & ~rsp_ready;

`ifdef ADDER_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always wins a conflict.
  always_comb begin
    gnt = 2'b00;
    if (!rst && !stall) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end
  end
`else
  logic ptr_q, ptr_d;

  // Round-robin grant: the pointer only matters when both requesters ask.
  always_comb begin
    gnt = 2'b00;
    if (!rst && !stall) begin
      if (req == 2'b11) gnt = ptr_q ? 2'b10 : 2'b01;
      else              gnt = req;
    end
  end

  // Pointer moves to the other requester after any grant, otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt[0])      ptr_d = 1'b1;
    else if (gnt[1]) ptr_d = 1'b0;
  end

  // Pointer register, reset to requester 0.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Shared adder tree on the granted requester's operands; each level widens by one bit.
  always_comb begin
    ops_sel = gnt[1] ? ops1 : ops0;
    for (int j = 0; j < 4; j++) begin
      lvl1[j] = {1'b0, ops_sel[(2*j)*WIDTH +: WIDTH]} + {1'b0, ops_sel[(2*j+1)*WIDTH +: WIDTH]};
    end
    for (int j = 0; j < 2; j++) begin
      lvl2[j] = {1'b0, lvl1[2*j]} + {1'b0, lvl1[2*j+1]};
    end
    lvl3 = {1'b0, lvl2[0]} + {1'b0, lvl2[1]};
  end

  // Pipeline next state: whole pipe holds on stall, otherwise shifts by one stage.
  always_comb begin
    vld_d = vld_q;
    for (int i = 0; i < LATENCY; i++) begin
      id_d[i]  = id_q[i];
      sum_d[i] = sum_q[i];
    end
    if (!stall) begin
      vld_d[0] = |gnt;
      id_d[0]  = gnt[1];
      sum_d[0] = (|gnt) ? lvl3 : '0;
      for (int i = 1; i < LATENCY; i++) begin
        vld_d[i] = vld_q[i-1];
        id_d[i]  = id_q[i-1];
        sum_d[i] = sum_q[i-1];
      end
    end
  end

  // Pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i]  <= 1'b0;
        sum_q[i] <= '0;
      end
    end else begin
      vld_q <= vld_d;
      for (int i = 0; i < LATENCY; i++) begin
        id_q[i]  <= id_d[i];
        sum_q[i] <= sum_d[i];
      end
    end
  end

endmodule

// File: doc/adder_tree_arbiter.md
ADDER_TREE_ARBITER -- requirements
Module: adder_tree_arbiter

Interface
REQ-001 Parameter WIDTH, default 24: bit width of each operand.
REQ-002 Parameter LATENCY, default 2, legal range 1..4: register stages between grant and response.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  2  per-requester request; bit i belongs to requester i.
REQ-006 ops0  input  8*WIDTH  requester 0 operands; operand k occupies bits [k*WIDTH +: WIDTH], unsigned.
REQ-007 ops1  input  8*WIDTH  requester 1 operands, same packing as ops0.
REQ-008 gnt  output  2  one-hot or zero grant, combinational, same cycle as the accepted req.
REQ-009 rsp_valid  output  1  rsp_sum and rsp_id are valid.
REQ-010 rsp_ready  input  1  consumer accepts the response.
REQ-011 rsp_id  output  1  index of the requester that owns the response.
REQ-012 rsp_sum  output  WIDTH+3  sum of the 8 granted operands.

Function
REQ-013 The block SHALL contain one shared 8-input, 3-level binary adder tree; level widths SHALL be WIDTH+1, WIDTH+2 and WIDTH+3, and no carry SHALL be lost.
REQ-014 stall SHALL be defined as rsp_valid AND NOT rsp_ready.
REQ-015 When stall is 0 and at least one req bit is 1, exactly one gnt bit SHALL be 1.
REQ-016 When stall is 1 or req is 0, gnt SHALL be 0.
REQ-017 Round-robin: with both req bits set, the requester named by the priority pointer SHALL be granted; with one req bit set, that requester SHALL be granted regardless of the pointer.
REQ-018 After a grant to requester i, the pointer SHALL select requester 1-i; the pointer SHALL hold when there is no grant.
REQ-019 A transaction SHALL be accepted in the cycle gnt[i]=1; ops_i and i SHALL be captured into stage 1 with a valid bit.
REQ-020 A requester SHALL hold req and its operands until granted; req held after a grant SHALL be treated as a new request.
REQ-021 Pipeline: LATENCY stages, each holding valid, id and data; an accept at edge T SHALL produce rsp_valid=1 after edge T+LATENCY-1 when no stall occurs.
REQ-022 While stall=1, all stages SHALL hold their contents, so no response is dropped or duplicated.
REQ-023 When stall=0, the pipeline SHALL advance every cycle, so throughput is one transaction per cycle.
REQ-024 A response SHALL retire on a cycle with rsp_valid=1 and rsp_ready=1; a new grant is permitted in that same cycle.
REQ-025 Responses SHALL leave in grant order.
REQ-026 rsp_sum and rsp_id SHALL be 0 whenever rsp_valid=0.

Reset
REQ-027 While rst=1, all valid bits, the pointer (selecting requester 0), rsp_valid, rsp_id and rsp_sum SHALL be 0; gnt SHALL be 0.
REQ-028 Reset asserted mid-operation SHALL discard all in-flight transactions without producing a response.
REQ-029 The first cycle after rst deasserts SHALL be able to grant.

Configuration
REQ-030 Macro ADDER_ARB_FIXED_PRIO_EN, when defined, SHALL select fixed priority: requester 0 wins every conflict and the pointer logic is removed.
REQ-031 Without ADDER_ARB_FIXED_PRIO_EN, arbitration SHALL be round-robin per REQ-017 and REQ-018.

Verification (LATENCY=2, WIDTH=24)
REQ-032 Single request: req=01, ops0 all operands = 0xFFFFFF -> gnt=01 immediately; one cycle later rsp_valid=1, rsp_id=0, rsp_sum=0x7FFFFF8.
REQ-033 Conflict: req=11 held for 4 cycles from reset -> gnt sequence 01,10,01,10; rsp_id sequence 0,1,0,1 (with the macro: 01,01,01,01).
REQ-034 Backpressure: stream of 3 grants, rsp_ready=0 for 3 cycles -> gnt=0 while stalled, rsp_sum/rsp_id stable, all 3 responses delivered in order after rsp_ready=1.
REQ-035 Reset mid-flight: assert rst one cycle after a grant -> no rsp_valid, pointer back to requester 0, and the next conflict grants requester 0.
REQ-036 Zero/carry: ops1 = {1,2,3,4,5,6,7,8} -> rsp_sum=36; ops with MSB-only values 0x800000 x8 -> rsp_sum=0x4000000.
